// File: rtl/dma_pkg.sv
// Shared constants and FSM state type for the CPU-side DMA bus responder.
package dma_pkg;

  localparam int unsigned DmaWordSize = 16;
  localparam logic [15:0] DmaDestAddr = 16'h01F4;
  localparam int unsigned DmaLength   = 12;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBr,
    StDrain,
    StGrant
  } dma_state_e;

endpackage

// File: rtl/dma_edge_detect.sv
// Registered rising-edge detector: rise_o is high in the cycle a level input goes 0->1.
module dma_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) d_q <= 1'b0;
    else         d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/dma_bus_responder.sv
// CPU-side DMA bus responder: issues the start command, grants the bus after the CPU drains,
// retires on the engine's end interrupt. Define DMA_STATS_EN to add grant/transfer counters.
module dma_bus_responder
  import dma_pkg::*;
#(
  parameter int unsigned                WORD_SIZE     = DmaWordSize,
  parameter logic [WORD_SIZE-1:0]       DMA_DEST_ADDR = WORD_SIZE'(DmaDestAddr),
  parameter int unsigned                DMA_LENGTH    = DmaLength,
  parameter int unsigned                LEN_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 dma_begin,
  input  logic                 dma_end,
  input  logic                 BR,
  input  logic                 cpu_mem_busy,
  output logic                 cmd,
  output logic [WORD_SIZE-1:0] cmd_addr,
  output logic [LEN_W-1:0]     cmd_len,
  output logic                 BG,
  output logic                 cpu_bus_hold,
  output logic                 dma_active
`ifdef DMA_STATS_EN
  ,
  output logic [WORD_SIZE-1:0] grant_cycles,
  output logic [WORD_SIZE-1:0] xfer_count
`endif
);

  logic       begin_rise, end_rise;
  dma_state_e state_q, state_d;
  logic       pending_q, pending_d;
  logic       cmd_q, cmd_d;
  logic       bg_q, bg_d;
  logic       active_q, active_d;
  logic       retire;

  dma_edge_detect u_begin_edge (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (dma_begin),
    .rise_o (begin_rise)
  );

  dma_edge_detect u_end_edge (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (dma_end),
    .rise_o (end_rise)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    retire    = 1'b0;
    unique case (state_q)
      StIdle: if (begin_rise) state_d = StIssue;
      StIssue: begin
        state_d = StWaitBr;
        if (begin_rise) pending_d = 1'b1;
      end
      StWaitBr, StDrain, StGrant: begin
        if (end_rise) begin
          // A start seen while busy (or coincident with the end) is issued right after retire.
          retire    = 1'b1;
          state_d   = (pending_q || begin_rise) ? StIssue : StIdle;
          pending_d = 1'b0;
        end else begin
          if (begin_rise) pending_d = 1'b1;
          case (state_q)
            StWaitBr: if (BR) state_d = cpu_mem_busy ? StDrain : StGrant;
            StDrain: begin
              if (!BR)                state_d = StWaitBr;
              else if (!cpu_mem_busy) state_d = StGrant;
            end
            default: if (!BR) state_d = StWaitBr;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase

    cmd_d    = (state_d == StIssue);
    bg_d     = (state_d == StGrant);
    active_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      cmd_q     <= 1'b0;
      bg_q      <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cmd_q     <= cmd_d;
      bg_q      <= bg_d;
      active_q  <= active_d;
    end
  end

  assign cmd          = cmd_q;
  assign cmd_addr     = cmd_q ? DMA_DEST_ADDR : '0;
  assign cmd_len      = cmd_q ? LEN_W'(DMA_LENGTH) : '0;
  assign BG           = bg_q;
  assign cpu_bus_hold = bg_q | (state_q == StDrain);
  assign dma_active   = active_q;

`ifdef DMA_STATS_EN
  logic [WORD_SIZE-1:0] grant_cycles_q, grant_cycles_d;
  logic [WORD_SIZE-1:0] xfer_count_q, xfer_count_d;

  always_comb begin
    grant_cycles_d = grant_cycles_q;
    xfer_count_d   = xfer_count_q;
    if (bg_q && !(&grant_cycles_q)) grant_cycles_d = grant_cycles_q + 1'b1;
    if (retire && !(&xfer_count_q)) xfer_count_d = xfer_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cycles_q <= '0;
      xfer_count_q   <= '0;
    end else begin
      grant_cycles_q <= grant_cycles_d;
      xfer_count_q   <= xfer_count_d;
    end
  end

  assign grant_cycles = grant_cycles_q;
  assign xfer_count   = xfer_count_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_dma_bus_responder.sv
// Self-checking bench for dma_bus_responder: directed protocol steps then random traffic,
// compared every cycle against a transaction-level reference model.
module tb_dma_bus_responder;

  logic        clk = 1'b0;
  logic        reset_n, dma_begin, dma_end, BR, cpu_mem_busy;
  logic        cmd, BG, cpu_bus_hold, dma_active;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
`ifdef DMA_STATS_EN
  logic [15:0] grant_cycles, xfer_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: transfer-level flags rather than an FSM encoding.
  bit          m_active, m_cmd, m_bg, m_drain, m_pend, m_bprev, m_eprev;
  logic [15:0] m_grant, m_xfer;

  dma_bus_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dma_begin    (dma_begin),
    .dma_end      (dma_end),
    .BR           (BR),
    .cpu_mem_busy (cpu_mem_busy),
    .cmd          (cmd),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .BG           (BG),
    .cpu_bus_hold (cpu_bus_hold),
    .dma_active   (dma_active)
`ifdef DMA_STATS_EN
    ,
    .grant_cycles (grant_cycles),
    .xfer_count   (xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_cmd = 0; m_bg = 0; m_drain = 0; m_pend = 0;
    m_bprev = 0; m_eprev = 0; m_grant = '0; m_xfer = '0;
  endtask

  task automatic model_update();
    bit brise, erise;
    if (!reset_n) begin
      model_reset();
      return;
    end
    brise   = dma_begin && !m_bprev;
    erise   = dma_end && !m_eprev;
    m_bprev = dma_begin;
    m_eprev = dma_end;
    if (m_bg && m_grant != 16'hFFFF) m_grant++;
    if (!m_active) begin
      if (brise) begin m_cmd = 1; m_active = 1; end
    end else if (m_cmd) begin
      m_cmd = 0;
      if (brise) m_pend = 1;
    end else if (erise) begin
      if (m_xfer != 16'hFFFF) m_xfer++;
      m_bg = 0; m_drain = 0;
      if (m_pend || brise) m_cmd = 1;
      else m_active = 0;
      m_pend = 0;
    end else begin
      if (brise) m_pend = 1;
      if (m_bg) m_bg = BR;
      else if (m_drain) begin
        if (!BR) m_drain = 0;
        else if (!cpu_mem_busy) begin m_drain = 0; m_bg = 1; end
      end else if (BR) begin
        if (cpu_mem_busy) m_drain = 1;
        else m_bg = 1;
      end
    end
  endtask

  task automatic check_all();
    check("cmd", cmd, m_cmd);
    check("cmd_addr", cmd_addr, m_cmd ? 32'h01F4 : 32'h0);
    check("cmd_len", cmd_len, m_cmd ? 32'd12 : 32'd0);
    check("BG", BG, m_bg);
    check("cpu_bus_hold", cpu_bus_hold, m_bg | m_drain);
    check("dma_active", dma_active, m_active);
`ifdef DMA_STATS_EN
    check("grant_cycles", grant_cycles, m_grant);
    check("xfer_count", xfer_count, m_xfer);
`endif
  endtask

  // One clock: model follows the posedge, DUT is checked at the following negedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset_n = 0; dma_begin = 0; dma_end = 0; BR = 0; cpu_mem_busy = 0;
    model_reset();
    repeat (2) tick();
    reset_n = 1;
    tick();

    // Start command: one cycle, fixed descriptor.
    dma_begin = 1; tick();
    check("t1_cmd", cmd, 1);
    check("t1_addr", cmd_addr, 16'h01F4);
    check("t1_len", cmd_len, 8'd12);
    dma_begin = 0; tick();
    check("t1_cmd_off", cmd, 0);

    // Three request bursts with the CPU idle.
    repeat (3) begin
      BR = 1; repeat (3) tick();
      BR = 0; repeat (2) tick();
    end

    // Request while the CPU access drains.
    cpu_mem_busy = 1; BR = 1; repeat (2) tick();
    check("t3_hold", cpu_bus_hold, 1);
    check("t3_bg_low", BG, 0);
    cpu_mem_busy = 0; tick();
    check("t3_bg_high", BG, 1);

    // Start during grant, then end: retire and immediate reissue.
    dma_begin = 1; tick();
    dma_begin = 0; tick();
    dma_end = 1; tick();
    check("t4_bg_off", BG, 0);
    check("t4_cmd2", cmd, 1);
    check("t4_addr2", cmd_addr, 16'h01F4);
    dma_end = 0; BR = 1; repeat (2) tick();

    // Async reset while granted with a pending start.
    dma_begin = 1; tick();
    dma_begin = 0; tick();
    check("t5_bg_before", BG, 1);
    #2 reset_n = 0;
    #1;
    model_reset();
    check("t5_bg_async", BG, 0);
    check("t5_hold_async", cpu_bus_hold, 0);
    check("t5_active_async", dma_active, 0);
    BR = 0;
    repeat (2) tick();
    reset_n = 1;
    repeat (3) tick();
    check("t5_no_pending_cmd", dma_active, 0);

    // Two transfers of 4 and 6 grant cycles.
    for (int k = 0; k < 2; k++) begin
      dma_begin = 1; tick();
      dma_begin = 0; BR = 1; tick();
      repeat (k == 0 ? 4 : 6) tick();
      BR = 0; tick();
      dma_end = 1; tick();
      dma_end = 0; tick();
    end
`ifdef DMA_STATS_EN
    check("t6_grant_cycles", grant_cycles, 16'd10);
    check("t6_xfer_count", xfer_count, 16'd2);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      dma_begin    = ($urandom_range(0, 5) == 0);
      dma_end      = ($urandom_range(0, 9) == 0);
      BR           = ($urandom_range(0, 2) != 0);
      cpu_mem_busy = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_bus_responder.md
Name: dma_bus_responder

Overview:
- CPU-side responder for the DMA bus protocol; sits inside the cpu between the external-device interrupt, the DMA engine's BR/interrupt lines and the CPU data-memory port.
- On the device's start interrupt it issues a one-cycle command with a fixed destination descriptor to the DMA engine.
- It answers the engine's bus request with a bus grant once the CPU's in-flight data access has drained, holding the CPU data port off the bus while granted.
- It retires the transfer on the engine's end interrupt.

Parameters:
- WORD_SIZE, 16, data/address word width.
- DMA_DEST_ADDR, 16'h01F4, memory destination address placed on cmd_addr.
- DMA_LENGTH, 12, number of words per transfer placed on cmd_len.
- LEN_W, 8, width of cmd_len.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- dma_begin  in  1  start interrupt from external device (level; rising edge detected internally).
- dma_end  in  1  end interrupt from DMA engine (level; rising edge detected internally).
- BR  in  1  bus request from DMA engine.
- cpu_mem_busy  in  1  CPU has a data-memory access (d_readM/d_writeM) in flight this cycle.
- cmd  out  1  one-cycle command strobe to DMA engine.
- cmd_addr  out  WORD_SIZE  destination address, valid when cmd=1.
- cmd_len  out  LEN_W  transfer length in words, valid when cmd=1.
- BG  out  1  bus grant to DMA engine.
- cpu_bus_hold  out  1  blocks new CPU data-memory accesses; high whenever BG is high or a grant is pending.
- dma_active  out  1  high from cmd until dma_end is retired.

Behaviour:
- Reset (async, reset_n=0): state IDLE; cmd=0, cmd_addr=0, cmd_len=0, BG=0, cpu_bus_hold=0, dma_active=0; pending-start flag and edge registers cleared. Reset mid-grant drops BG immediately (asynchronously).
- Edge detect: begin_rise = dma_begin & ~dma_begin_q; end_rise likewise; registers sample each clk.
- State machine:
  - IDLE: on begin_rise -> ISSUE.
  - ISSUE: cmd=1, cmd_addr=DMA_DEST_ADDR, cmd_len=DMA_LENGTH for exactly one cycle; dma_active set. Next -> WAIT_BR.
  - WAIT_BR: if BR=1 and cpu_mem_busy=0 -> GRANT. If BR=1 and cpu_mem_busy=1 -> DRAIN. If end_rise -> IDLE.
  - DRAIN: cpu_bus_hold=1 so no new CPU access starts; when cpu_mem_busy=0 -> GRANT. If BR drops while in DRAIN -> WAIT_BR without granting.
  - GRANT: BG=1, cpu_bus_hold=1. When BR=0 -> WAIT_BR, with BG low the cycle after BR is sampled low. The engine may re-request for cycle stealing.
  - end_rise in WAIT_BR/DRAIN/GRANT: dma_active cleared -> IDLE (BG forced 0 at the same edge).
- Latency:
  - begin_rise to cmd: 1 cycle.
  - BR high (CPU idle) to BG high: 1 cycle.
  - BR low to BG low: 1 cycle.
- cmd_addr/cmd_len return to 0 when cmd=0.
- Simultaneous events:
  - begin_rise while dma_active=1 sets the pending flag; it is not dropped. On retire the FSM goes to ISSUE instead of IDLE, so the next cmd follows 1 cycle after the end. A second begin while one is already pending is coalesced.
  - end_rise and begin_rise in the same cycle: retire, then ISSUE next.
  - BR=1 outside WAIT_BR/DRAIN/GRANT (IDLE/ISSUE): ignored; BG stays 0.
- BG and cmd are registered outputs; cpu_bus_hold = BG | (state==DRAIN).

Optional Feature:
- Macro: DMA_STATS_EN.
- Defined: adds outputs grant_cycles (WORD_SIZE) and xfer_count (WORD_SIZE), both reset to 0.
  - grant_cycles increments every cycle BG=1.
  - xfer_count increments on each retire.
  - Both saturate at all-ones.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package (dma_pkg): WORD_SIZE constant, FSM state encoding (IDLE, ISSUE, WAIT_BR, DRAIN, GRANT), default DMA_DEST_ADDR and DMA_LENGTH.
- One natural sub-module: dma_edge_detect (registered rising-edge detector, instantiated for dma_begin and dma_end).

Test Plan:
1. Reset release, then pulse dma_begin -> cmd=1 for exactly 1 cycle with cmd_addr=16'h01F4, cmd_len=12; dma_active=1.
2. BR=1 with cpu_mem_busy=0 -> BG=1 next cycle; BR held 3 cycles then 0 -> BG low 1 cycle after BR low; three request bursts each granted.
3. BR=1 while cpu_mem_busy=1 for 2 cycles -> cpu_bus_hold=1 immediately, BG=0 until busy drops, then BG=1 the following cycle.
4. dma_begin pulsed again during GRANT, then dma_end -> BG=0, dma_active drops, second cmd issued 1 cycle after the retire, with identical descriptor.
5. Assert reset_n=0 while BG=1 -> BG, cpu_bus_hold, dma_active all 0 without waiting for clk; after release a pending start is not issued.
6. With DMA_STATS_EN: two transfers of 4 and 6 grant cycles -> grant_cycles=10, xfer_count=2.
